// File: rtl/xillybus_loopback_fifo_32.sv
// Loopback FIFO for the 32-bit Xillybus stream pair.
// Host writes on user_w_write_32_* are buffered and returned on user_r_read_32_*.
// The read side is a standard (non-FWFT) FIFO: data appears the cycle after rd_en.
// EOF is raised once the writer has closed and the buffer is empty.
// Closing both device files flushes pointers and count; RAM contents are kept.
// Optional statistics ports (words_total, overflow, underflow) are enabled by
// defining XILLYBUS_LOOPBACK_STATS_EN.
module xillybus_loopback_fifo_32 #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  bus_clk,
  input  logic                  quiesce,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  wr_open,
  output logic                  wr_full,
  input  logic                  rd_en,
  input  logic                  rd_open,
  output logic [31:0]           rd_data,
  output logic                  rd_empty,
  output logic                  rd_eof,
  output logic [DEPTH_LOG2:0]   fill
`ifdef XILLYBUS_LOOPBACK_STATS_EN
  ,
  output logic [31:0]           words_total,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FILL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   FILL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_EOF
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   fill_next;
  logic                  flush;
  logic                  wr_accept;
  logic                  rd_accept;

  // Handshake qualification and next word count; flush overrides both sides.
  always_comb begin
    flush     = !wr_open && !rd_open;
    wr_accept = wr_en && !wr_full && !flush;
    rd_accept = rd_en && !rd_empty && !flush;
    fill_next = fill;
    if (flush) begin
      fill_next = '0;
    end else if (wr_accept && !rd_accept) begin
      fill_next = fill + FILL_ONE;
    end else if (!wr_accept && rd_accept) begin
      fill_next = fill - FILL_ONE;
    end
  end

  // Next-state logic for the stream lifecycle (open, draining, end-of-file).
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_open) state_next = S_STREAM;
        end
        S_STREAM: begin
          if (!wr_open) state_next = (fill != '0) ? S_DRAIN : S_EOF;
        end
        S_DRAIN: begin
          if (wr_open) begin
            state_next = S_STREAM;
          end else if (fill == '0) begin
            state_next = S_EOF;
          end
        end
        S_EOF: begin
          if (wr_open) state_next = S_STREAM;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge bus_clk or posedge quiesce) begin
    if (quiesce) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Storage array; left without reset so it maps onto block RAM.
  always_ff @(posedge bus_clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, count and registered flags, all derived from the next count.
  always_ff @(posedge bus_clk or posedge quiesce) begin
    if (quiesce) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      wr_full  <= 1'b0;
      rd_empty <= 1'b1;
      rd_eof   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
      end
      fill     <= fill_next;
      wr_full  <= (fill_next == FILL_FULL);
      rd_empty <= (fill_next == '0);
      rd_eof   <= (state_next == S_EOF);
    end
  end

  // Read data register; holds its value unless a read is accepted.
  always_ff @(posedge bus_clk or posedge quiesce) begin
    if (quiesce) begin
      rd_data <= '0;
    end else if (rd_accept) begin
      rd_data <= mem[rd_ptr];
    end
  end

`ifdef XILLYBUS_LOOPBACK_STATS_EN
  // Accepted-word counter and sticky misuse flags, cleared on flush.
  always_ff @(posedge bus_clk or posedge quiesce) begin
    if (quiesce) begin
      words_total <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (flush) begin
      words_total <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_accept) words_total <= words_total + 32'd1;
      if (wr_en && wr_full) overflow <= 1'b1;
      if (rd_en && rd_empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_xillybus_loopback_fifo_32.sv
// Self-checking bench for xillybus_loopback_fifo_32.
// Stimulus pushes expected read words into a scoreboard queue; a monitor
// process pops and compares whenever the DUT accepts a read.
// Statistics checks are compiled in when XILLYBUS_LOOPBACK_STATS_EN is defined.
module tb_xillybus_loopback_fifo_32;

  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH = 512;

  logic                bus_clk = 1'b0;
  logic                quiesce;
  logic                wr_en;
  logic [31:0]         wr_data;
  logic                wr_open;
  logic                wr_full;
  logic                rd_en;
  logic                rd_open;
  logic [31:0]         rd_data;
  logic                rd_empty;
  logic                rd_eof;
  logic [DEPTH_LOG2:0] fill;
`ifdef XILLYBUS_LOOPBACK_STATS_EN
  logic [31:0]         words_total;
  logic                overflow;
  logic                underflow;
`endif

  int          checks_total;
  int          checks_passed;
  logic [31:0] sb_q[$];
  logic [31:0] model_q[$];
  logic [31:0] last_read;
  logic [31:0] mon_exp;
  bit          pending;

  xillybus_loopback_fifo_32 #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .bus_clk  (bus_clk),
    .quiesce  (quiesce),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_open  (wr_open),
    .wr_full  (wr_full),
    .rd_en    (rd_en),
    .rd_open  (rd_open),
    .rd_data  (rd_data),
    .rd_empty (rd_empty),
    .rd_eof   (rd_eof),
    .fill     (fill)
`ifdef XILLYBUS_LOOPBACK_STATS_EN
    ,
    .words_total (words_total),
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  always #5 bus_clk = ~bus_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, predict acceptance from the bench model,
  // queue the expected read word, then let one rising edge consume them.
  task automatic applyStimulus(input logic wen, input logic [31:0] wdata, input logic ren);
    bit flush_now;
    bit wr_acc;
    bit rd_acc;
    wr_en     = wen;
    wr_data   = wdata;
    rd_en     = ren;
    flush_now = !wr_open && !rd_open;
    rd_acc    = ren && (model_q.size() != 0) && !flush_now;
    wr_acc    = wen && (model_q.size() < DEPTH) && !flush_now;
    if (flush_now) model_q.delete();
    if (rd_acc) sb_q.push_back(model_q.pop_front());
    if (wr_acc) model_q.push_back(wdata);
    @(posedge bus_clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Monitor: a read seen accepted before an edge is checked at the next falling edge.
  initial begin
    forever begin
      @(negedge bus_clk);
      if (quiesce) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (sb_q.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL unexpected_read: got 0x%08h, expected no read at %0t", rd_data, $time);
          end else begin
            mon_exp = sb_q.pop_front();
            checkOutput("rd_data", rd_data, mon_exp);
            last_read = mon_exp;
          end
        end
        pending = rd_en && !rd_empty && (wr_open || rd_open);
      end
    end
  end

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    pending       = 1'b0;
    last_read     = 32'h0;
    quiesce       = 1'b1;
    wr_en         = 1'b0;
    wr_data       = 32'h0;
    rd_en         = 1'b0;
    wr_open       = 1'b0;
    rd_open       = 1'b0;
    repeat (3) @(posedge bus_clk);
    #1;

    // Reset values
    checkOutput("reset_wr_full",  32'(wr_full),  32'd0);
    checkOutput("reset_rd_empty", 32'(rd_empty), 32'd1);
    checkOutput("reset_rd_eof",   32'(rd_eof),   32'd0);
    checkOutput("reset_rd_data",  rd_data,       32'd0);
    checkOutput("reset_fill",     32'(fill),     32'd0);
`ifdef XILLYBUS_LOOPBACK_STATS_EN
    checkOutput("reset_words_total", words_total, 32'd0);
    checkOutput("reset_overflow",    32'(overflow),  32'd0);
`endif
    quiesce = 1'b0;
    wr_open = 1'b1;
    rd_open = 1'b1;

    // Basic write of four words then four reads
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b0);
    checkOutput("t1_fill",     32'(fill),     32'd4);
    checkOutput("t1_rd_empty", 32'(rd_empty), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1_rd_empty_after", 32'(rd_empty), 32'd1);
    checkOutput("t1_fill_after",     32'(fill),     32'd0);
    checkOutput("t1_last_word",      rd_data,       32'd4);

    // Fill to capacity, drop an overflow write, then full with simultaneous read/write
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
    checkOutput("t2_wr_full", 32'(wr_full), 32'd1);
    checkOutput("t2_fill",    32'(fill),    32'd512);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("t2_fill_drop", 32'(fill), 32'd512);
`ifdef XILLYBUS_LOOPBACK_STATS_EN
    checkOutput("t2_overflow",    32'(overflow),  32'd1);
    checkOutput("t2_underflow",   32'(underflow), 32'd0);
    checkOutput("t2_words_total", words_total,    32'd516);
`endif
    applyStimulus(1'b1, 32'hCAFE_0000, 1'b1);
    checkOutput("t4_full_rw_fill",    32'(fill),    32'd511);
    checkOutput("t4_full_rw_wr_full", 32'(wr_full), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t2_rd_empty", 32'(rd_empty), 32'd1);
    checkOutput("t2_fill_end", 32'(fill),     32'd0);
    checkOutput("t2_last_word", rd_data,      32'h1000_01FF);

    // Empty FIFO with simultaneous write and read: write only
    applyStimulus(1'b1, 32'h0000_ABCD, 1'b1);
    checkOutput("t4_empty_rw_fill",     32'(fill),     32'd1);
    checkOutput("t4_empty_rw_rd_empty", 32'(rd_empty), 32'd0);
    checkOutput("t4_rd_data_hold",      rd_data,       32'h1000_01FF);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4_read_back", rd_data, 32'h0000_ABCD);
`ifdef XILLYBUS_LOOPBACK_STATS_EN
    checkOutput("t4_underflow",   32'(underflow), 32'd1);
    checkOutput("t4_words_total", words_total,    32'd517);
`endif

    // Writer closes with data pending: drain, then EOF, then reopen
    applyStimulus(1'b1, 32'h0000_00A1, 1'b0);
    applyStimulus(1'b1, 32'h0000_00A2, 1'b0);
    applyStimulus(1'b1, 32'h0000_00A3, 1'b0);
    wr_open = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_drain_rd_eof", 32'(rd_eof), 32'd0);
    checkOutput("t3_drain_fill",   32'(fill),   32'd3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_eof_rd_eof",   32'(rd_eof),   32'd1);
    checkOutput("t3_eof_rd_empty", 32'(rd_empty), 32'd1);
    wr_open = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_reopen_rd_eof", 32'(rd_eof), 32'd0);

    // Both files close with 100 words buffered: flush beats a concurrent write/read
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
    checkOutput("t5_fill", 32'(fill), 32'd100);
    wr_open = 1'b0;
    rd_open = 1'b0;
    applyStimulus(1'b1, 32'hBAD0_0000, 1'b1);
    checkOutput("t5_flush_fill",     32'(fill),     32'd0);
    checkOutput("t5_flush_rd_empty", 32'(rd_empty), 32'd1);
    checkOutput("t5_flush_rd_eof",   32'(rd_eof),   32'd0);
    checkOutput("t5_flush_wr_full",  32'(wr_full),  32'd0);
    checkOutput("t5_flush_rd_data",  rd_data,       32'h0000_00A3);
`ifdef XILLYBUS_LOOPBACK_STATS_EN
    checkOutput("t5_flush_words_total", words_total,    32'd0);
    checkOutput("t5_flush_overflow",    32'(overflow),  32'd0);
    checkOutput("t5_flush_underflow",   32'(underflow), 32'd0);
`endif
    wr_open = 1'b1;
    rd_open = 1'b1;
    applyStimulus(1'b1, 32'h6000_0001, 1'b0);
    applyStimulus(1'b1, 32'h6000_0002, 1'b0);
    checkOutput("t5_refill", 32'(fill), 32'd2);
`ifdef XILLYBUS_LOOPBACK_STATS_EN
    checkOutput("t5_words_total", words_total, 32'd2);
`endif
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t5_read_back", rd_data, 32'h6000_0002);

    // Asynchronous quiesce in the middle of a write burst
    applyStimulus(1'b1, 32'h7000_0001, 1'b0);
    applyStimulus(1'b1, 32'h7000_0002, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    wr_en   = 1'b1;
    wr_data = 32'h7000_0003;
    #3;
    quiesce = 1'b1;
    #1;
    checkOutput("t6_q_wr_full",  32'(wr_full),  32'd0);
    checkOutput("t6_q_rd_empty", 32'(rd_empty), 32'd1);
    checkOutput("t6_q_rd_eof",   32'(rd_eof),   32'd0);
    checkOutput("t6_q_rd_data",  rd_data,       32'd0);
    checkOutput("t6_q_fill",     32'(fill),     32'd0);
`ifdef XILLYBUS_LOOPBACK_STATS_EN
    checkOutput("t6_q_words_total", words_total, 32'd0);
`endif
    wr_en = 1'b0;
    @(posedge bus_clk);
    #1;
    model_q.delete();
    sb_q.delete();
    last_read = 32'h0;
    quiesce   = 1'b0;
    applyStimulus(1'b1, 32'h7777_0000, 1'b0);
    checkOutput("t6_recover_fill", 32'(fill), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t6_recover_data", rd_data, 32'h7777_0000);

    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/xillybus_loopback_fifo_32.md
Name: xillybus_loopback_fifo_32

Overview:
- Downstream consumer of the 32-bit Xillybus stream pair; loops host writes back to host reads.
- Buffers words from user_w_write_32_* and serves them on user_r_read_32_*.
- Generates end-of-file once the writer has closed and the buffer has drained.
- Self-flushes when both device files are closed.

Parameters:
DEPTH_LOG2, 9, log2 of FIFO depth in 32-bit words (DEPTH = 2**DEPTH_LOG2 = 512)

Ports:
bus_clk  in  1  bus clock from PCIe core; all logic on rising edge
quiesce  in  1  asynchronous, active-high reset
wr_en  in  1  user_w_write_32_wren
wr_data  in  32  user_w_write_32_data
wr_open  in  1  user_w_write_32_open
wr_full  out  1  user_w_write_32_full
rd_en  in  1  user_r_read_32_rden
rd_open  in  1  user_r_read_32_open
rd_data  out  32  user_r_read_32_data
rd_empty  out  1  user_r_read_32_empty
rd_eof  out  1  user_r_read_32_eof
fill  out  DEPTH_LOG2+1  current word count

Behaviour:
- Clock and reset: one clock, bus_clk. Reset is quiesce, asynchronous and active-high.
- Reset values: wr_full=0, rd_empty=1, rd_eof=0, rd_data=0, fill=0, pointers=0, state=IDLE.
- Storage: DEPTH x 32 dual-port RAM. Write and read pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- Write: accepted when wr_en=1 and wr_full=0. The RAM and fill update on the same edge. wr_en while full is dropped; the pointer does not move.
- Read: standard (non-FWFT) FIFO. rd_en=1 with rd_empty=0 presents the head word on rd_data the cycle after rd_en. rd_en while empty is ignored and rd_data holds.
- Simultaneous accepted read and write: fill is unchanged and both pointers advance.
- Write to an empty FIFO: rd_empty deasserts on the next cycle (one-cycle write-to-read latency). A rd_en in that same cycle is ignored.
- Flags are registered from next-state fill:
  - wr_full=1 iff fill==DEPTH.
  - rd_empty=1 iff fill==0.
  - fill never exceeds DEPTH and never underflows.
- FSM:
  - IDLE: wr_open=1 -> STREAM.
  - STREAM: wr_open=0 and fill!=0 -> DRAIN. wr_open=0 and fill==0 -> EOF.
  - DRAIN: fill reaches 0 -> EOF. wr_open=1 (writer reopened) -> STREAM.
  - EOF: rd_eof=1, rd_empty=1. wr_open=1 -> STREAM, rd_eof drops the next cycle.
- rd_eof is registered and asserted only in EOF. A write arriving in EOF is impossible because wr_open must rise first.
- Flush: if wr_open=0 and rd_open=0 on any edge:
  - pointers and fill clear, state -> IDLE, rd_eof=0;
  - RAM contents are not cleared; rd_data holds.
  - Flush has priority over read and write in the same cycle.
- Reset mid-transfer: quiesce clears everything immediately, regardless of state. In-flight words are lost.

Optional Feature:
- Macro: XILLYBUS_LOOPBACK_STATS_EN.
- When defined, three output ports are added:
  - words_total (32-bit): increments on every accepted write and wraps at 2^32.
  - overflow (1-bit, sticky): set by any wr_en while wr_full=1.
  - underflow (1-bit, sticky): set by any rd_en while rd_empty=1.
- All three clear on quiesce or flush.
- When not defined, these ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then write 0x00000001..0x00000004 with rd_open=1 -> fill=4. Four rd_en pulses return 1,2,3,4, each one cycle after rd_en. rd_empty=1 after the 4th.
- Write 512 words -> wr_full=1 at fill=512. A 513th wr_en (0xDEADBEEF) is dropped. Reads return exactly the 512 words in order; overflow=1 if stats enabled.
- Writer writes 3 words then drops wr_open -> state DRAIN, rd_eof=0. After 3 reads rd_eof=1 and rd_empty=1. Raise wr_open -> rd_eof=0 the next cycle.
- Full FIFO with simultaneous wr_en/rd_en -> write dropped, read accepted, fill 512->511. Empty FIFO with simultaneous wr_en/rd_en -> write accepted, read ignored, fill 0->1.
- Fill 100 words, drop wr_open and rd_open together -> fill=0, rd_empty=1, rd_eof=0, state IDLE on the next edge.
- Assert quiesce asynchronously mid-burst -> all outputs at reset values before the next bus_clk edge.
